// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory read port, redirect/halt control,
// and the decode-side valid/ready output with the delivered-instruction count.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [15:0] fetched_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fetched_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fetched_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Program counter and fetch register feeding decode over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset, no fetch while memory init settles
// RUN   | fetching, one word per cycle when decode keeps up
// HALT  | no new fetches; a held word may still be taken by decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 32
) (
  input  logic       clk,
  input  logic       reset,
  fetch_stage_if.master bus
);

  // PC arithmetic is kept modulo the memory size so upper address bits stay 0.
  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic [15:0] count_q;

  logic xfer;
  logic redir;
  logic load;

  assign xfer  = out_valid_q & bus.out_ready;
  assign redir = bus.redirect_valid & (state_q != BOOT);
  assign load  = (state_q == RUN) & ~bus.halt & (~out_valid_q | bus.out_ready);

  // Next-state decode; halt is level-sensitive in both directions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt)  state_d = HALT;
      HALT:    if (!bus.halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // PC, output register and counter; a redirect flushes the held word but the
  // same-cycle transfer still counts because decode already took it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC & PC_MASK;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
      count_q     <= 16'h0;
    end else begin
      if (xfer) count_q <= count_q + 16'd1;
      if (redir) begin
        pc_q        <= {bus.redirect_pc[31:2], 2'b00} & PC_MASK;
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_instr_q <= bus.imem_data;
        out_pc_q    <= pc_q;
        out_valid_q <= 1'b1;
        pc_q        <= (pc_q + 32'd4) & PC_MASK;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_instr     = out_instr_q;
  assign bus.out_pc        = out_pc_q;
  assign bus.fetched_count = count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Program-counter and fetch-register stage of the instruction fetch unit, directly upstream of the byte-addressable instruction memory. It owns the PC, drives it to the memory's combinational read port, and captures the returned 32-bit instruction word into an output register. The decode stage consumes that register through a valid/ready handshake. The block also supports redirects (branch/jump) and halting, and counts delivered instructions.

## Interface
- RESET_PC, 0: first fetch address after reset; must be word-aligned and < MEM_BYTES.
- MEM_BYTES, 32: instruction memory size in bytes; power of two, multiple of 4.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high; also wired to the memory's init input.
- imem_addr  out  32  fetch address to the instruction memory; always equals pc_q.
- imem_data  in  32  instruction word read combinationally at imem_addr.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  32  redirect target.
- halt  in  1  stop issuing new fetches while high.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  fetched instruction word.
- out_pc  out  32  address of out_instr.
- fetched_count  out  16  number of completed handshakes, wraps at 2^16.

## Operation
- States:
  - BOOT: one cycle after reset; no fetch, which lets memory init settle.
  - RUN: fetching.
  - HALT: no new fetches.
- Transitions: BOOT -> RUN unconditionally. RUN -> HALT when halt=1. HALT -> RUN when halt=0.
- Reset values: state=BOOT, pc_q=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetched_count=0.
- Transfer: out_valid & out_ready. A transfer increments fetched_count by 1, mod 2^16, in any state.
- Load condition, RUN with halt=0 only: (!out_valid | out_ready).
  - On load: out_instr<=imem_data, out_pc<=pc_q, out_valid<=1, pc_q<=(pc_q+4) mod MEM_BYTES.
- No load while not in RUN:
  - A transfer clears out_valid.
  - Otherwise out_valid, out_instr and out_pc hold.
- Backpressure: while out_valid=1 and out_ready=0, out_instr, out_pc and pc_q are stable.
- Redirect (any state except BOOT) has priority over load:
  - pc_q <= {redirect_pc[31:2],2'b00} mod MEM_BYTES.
  - out_valid <= 0, flushing the wrong-path instruction.
  - A transfer in the same cycle still counts, since decode took the old word.
  - Redirect in BOOT is ignored.
- halt and redirect together: the redirect is applied and the state moves to HALT.
- Wrap-around: PC after MEM_BYTES-4 is 0.
- Address width: imem_addr upper bits above log2(MEM_BYTES) are always 0.

## Timing
- Edges are numbered from the first rising edge with reset=0, called E1.
  - E1: BOOT -> RUN.
  - E2: first load; out_valid=1 with out_pc=RESET_PC after E2.
- Throughput: with out_ready=1 and no halt/redirect, one instruction per cycle.
- Redirect sampled at edge En:
  - out_valid=0 after En.
  - The target instruction is valid after En+1, giving a 1-cycle bubble.
- halt sampled high at En: no load at En.
- halt low sampled at Em (state HALT): state RUN after Em, first load at Em+1.
- Reset asserted mid-operation: all registers take reset values at that edge. Any pending instruction is dropped uncounted.

## Test plan
- Memory preloaded with 0x00940333, 0x413903b3, 0x035a02b3, 0x017b4e33, 0x019c1eb3, 0x01bd5f33, 0x00d67fb3, 0x00f768b3 at bytes 0,4,...,28.
- Reset then stream, out_ready=1: out_valid first high after E2 with out_pc=0, out_instr=0x00940333. The next 7 cycles yield pc 4..28 with matching words. After pc 28 (0x00f768b3), pc wraps to 0 (0x00940333). fetched_count=9 after 9 transfers.
- Backpressure: drop out_ready for 3 cycles while out_pc=8. out_instr stays 0x035a02b3 and imem_addr stays 12. After release, the next word is 0x017b4e33 at pc 12, none skipped or duplicated.
- Redirect: redirect_pc=0x13 while out_pc=4 is valid and out_ready=1. fetched_count counts pc 4. out_valid=0 for one cycle, then out_pc=0x10, out_instr=0x019c1eb3, then pc 0x14 with 0x01bd5f33.
- Halt: assert halt for 4 cycles with out_ready=1. At most the held word transfers, then out_valid=0 and imem_addr is frozen. Deassert halt: the fetch resumes at the frozen address one cycle later.
- Reset mid-stream at out_pc=20: after the reset edge, out_valid=0 and fetched_count=0. The stream restarts at pc 0 per the reset timing.
